// File: rtl/lc3_alu_pkg.sv
// Shared types, opcode constants and helper functions for the LC-3 ALU issue controller.
package lc3_alu_pkg;

    localparam int LC3_W = 16;

    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_NOT = 4'b1001;

    typedef enum logic [1:0] {
        ALUK_ADD  = 2'b00,
        ALUK_AND  = 2'b01,
        ALUK_NOT  = 2'b10,
        ALUK_PASS = 2'b11
    } aluk_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        EXEC = 2'd2,
        WB   = 2'd3
    } state_t;

    function automatic logic [LC3_W-1:0] sext5(input logic [4:0] imm);
        return {{(LC3_W-5){imm[4]}}, imm};
    endfunction

    // Exactly one condition bit is set for any result.
    function automatic logic [2:0] nzp_of(input logic [LC3_W-1:0] res);
        if (res[LC3_W-1])
            return 3'b100;
        else if (res == '0)
            return 3'b010;
        else
            return 3'b001;
    endfunction

    function automatic logic is_alu_op(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_AND) || (op == OP_NOT);
    endfunction

    function automatic aluk_t aluk_of(input logic [3:0] op);
        case (op)
            OP_ADD:  return ALUK_ADD;
            OP_AND:  return ALUK_AND;
            OP_NOT:  return ALUK_NOT;
            default: return ALUK_PASS;
        endcase
    endfunction

endpackage

// File: rtl/alu_issue_ctrl_nzp.sv
// Condition-code register: loads {N,Z,P} from a result when enabled.
module nzp_reg
    import lc3_alu_pkg::*;
#(
    parameter int         DATA_W  = 16,
    parameter logic [2:0] NZP_RST = 3'b010
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] res,
    output logic [2:0]        nzp
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            nzp <= NZP_RST;
        else if (load)
            nzp <= nzp_of(res);
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// LC-3 ALU issue controller: IDLE/READ/EXEC/WB sequencing of ADD/AND/NOT.
// Optional overflow flag output enabled by defining ALU_OVF_EN.
module alu_issue_ctrl
    import lc3_alu_pkg::*;
#(
    parameter int         DATA_W  = 16,
    parameter int         REG_AW  = 3,
    parameter logic [2:0] NZP_RST = 3'b010
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic [15:0]       Instr,
    input  logic              Instr_valid,
    output logic              Instr_ready,
    output logic [REG_AW-1:0] SR1_addr,
    output logic [REG_AW-1:0] SR2_addr,
    input  logic [DATA_W-1:0] SR1_data,
    input  logic [DATA_W-1:0] SR2_data,
    output logic [DATA_W-1:0] ALU_A,
    output logic [DATA_W-1:0] ALU_B,
    output logic [1:0]        ALUK,
    input  logic [DATA_W-1:0] ALU_Dout,
    output logic [REG_AW-1:0] DR_addr,
    output logic [DATA_W-1:0] DR_data,
    output logic              DR_we,
    output logic [2:0]        NZP,
    output logic              Illegal_op
`ifdef ALU_OVF_EN
    ,
    output logic              Ovf
`endif
);

    state_t            state;
    logic [15:0]       ir;
    logic [DATA_W-1:0] a_reg;
    logic [DATA_W-1:0] b_reg;
    logic [DATA_W-1:0] res_reg;
    aluk_t             aluk_q;
    logic [3:0]        op;

    assign op       = ir[15:12];
    assign SR1_addr = ir[8:6];
    assign SR2_addr = ir[2:0];
    assign DR_addr  = ir[11:9];
    assign DR_data  = res_reg;
    assign ALU_A    = a_reg;
    assign ALU_B    = b_reg;
    assign ALUK     = aluk_q;

    // a_reg/b_reg/aluk_q only change on the READ->EXEC edge, so ALU inputs hold outside EXEC.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state       <= IDLE;
            ir          <= '0;
            a_reg       <= '0;
            b_reg       <= '0;
            res_reg     <= '0;
            aluk_q      <= ALUK_PASS;
            Instr_ready <= 1'b1;
            DR_we       <= 1'b0;
            Illegal_op  <= 1'b0;
        end else begin
            DR_we      <= 1'b0;
            Illegal_op <= 1'b0;
            case (state)
                IDLE: begin
                    if (Instr_valid) begin
                        ir <= Instr;
                        if (is_alu_op(Instr[15:12])) begin
                            state       <= READ;
                            Instr_ready <= 1'b0;
                        end else begin
                            Illegal_op <= 1'b1;
                        end
                    end
                end
                READ: begin
                    a_reg <= SR1_data;
                    if (op == OP_NOT)
                        b_reg <= '1;
                    else if (ir[5])
                        b_reg <= sext5(ir[4:0]);
                    else
                        b_reg <= SR2_data;
                    aluk_q <= aluk_of(op);
                    state  <= EXEC;
                end
                EXEC: begin
                    res_reg <= ALU_Dout;
                    DR_we   <= 1'b1;
                    state   <= WB;
                end
                WB: begin
                    Instr_ready <= 1'b1;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    nzp_reg #(
        .DATA_W  (DATA_W),
        .NZP_RST (NZP_RST)
    ) u_nzp (
        .clk   (Clk),
        .rst_n (Reset_n),
        .load  (state == WB),
        .res   (res_reg),
        .nzp   (NZP)
    );

`ifdef ALU_OVF_EN
    // Signed overflow: operands agree in sign but the result does not.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n)
            Ovf <= 1'b0;
        else if (state == WB)
            Ovf <= (op == OP_ADD) &&
                   (a_reg[DATA_W-1] == b_reg[DATA_W-1]) &&
                   (res_reg[DATA_W-1] != a_reg[DATA_W-1]);
    end
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: vector table, random ops and reset abort sequence.
module tb_alu_issue_ctrl;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic [15:0] Instr;
    logic        Instr_valid;
    logic        Instr_ready;
    logic [2:0]  SR1_addr, SR2_addr, DR_addr;
    logic [15:0] SR1_data, SR2_data, ALU_A, ALU_B, ALU_Dout, DR_data;
    logic [1:0]  ALUK;
    logic        DR_we;
    logic [2:0]  NZP;
    logic        Illegal_op;
`ifdef ALU_OVF_EN
    logic        Ovf;
`endif

    always #5 Clk = ~Clk;

    alu_issue_ctrl dut (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .Instr       (Instr),
        .Instr_valid (Instr_valid),
        .Instr_ready (Instr_ready),
        .SR1_addr    (SR1_addr),
        .SR2_addr    (SR2_addr),
        .SR1_data    (SR1_data),
        .SR2_data    (SR2_data),
        .ALU_A       (ALU_A),
        .ALU_B       (ALU_B),
        .ALUK        (ALUK),
        .ALU_Dout    (ALU_Dout),
        .DR_addr     (DR_addr),
        .DR_data     (DR_data),
        .DR_we       (DR_we),
        .NZP         (NZP),
        .Illegal_op  (Illegal_op)
`ifdef ALU_OVF_EN
        ,
        .Ovf         (Ovf)
`endif
    );

    // Register file and ALU models
    logic [15:0] rf [8];
    logic        pl_en = 1'b0;
    logic [2:0]  pl_ia, pl_ib;
    logic [15:0] pl_va, pl_vb;

    assign SR1_data = rf[SR1_addr];
    assign SR2_data = rf[SR2_addr];

    always @(posedge Clk) begin
        if (pl_en) begin
            rf[pl_ia] <= pl_va;
            rf[pl_ib] <= pl_vb;
        end else if (DR_we) begin
            rf[DR_addr] <= DR_data;
        end
    end

    always_comb begin
        ALU_Dout = ALU_A;
        case (ALUK)
            2'b00:   ALU_Dout = ALU_A + ALU_B;
            2'b01:   ALU_Dout = ALU_A & ALU_B;
            2'b10:   ALU_Dout = ALU_A ^ 16'hFFFF;
            default: ALU_Dout = ALU_A;
        endcase
    end

    typedef struct {
        logic [2:0]  ra;
        logic [15:0] va;
        logic [2:0]  rb;
        logic [15:0] vb;
        logic [15:0] instr;
        logic        legal;
        logic [1:0]  aluk;
        logic [15:0] alub;
        logic [2:0]  dr;
        logic [15:0] data;
        logic [2:0]  nzp;
        logic        ovf;
    } vec_t;

    typedef struct {
        logic [2:0]  dr;
        logic [15:0] data;
        logic [2:0]  nzp;
        logic        ovf;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    logic [2:0] cur_nzp = 3'b010;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endtask

    function automatic vec_t mk(input logic [2:0] ra, input logic [15:0] va,
                                input logic [2:0] rb, input logic [15:0] vb,
                                input logic [15:0] instr, input logic legal,
                                input logic [1:0] aluk, input logic [15:0] alub,
                                input logic [2:0] dr, input logic [15:0] data,
                                input logic [2:0] nzp, input logic ovf);
        vec_t v;
        v.ra = ra; v.va = va; v.rb = rb; v.vb = vb; v.instr = instr; v.legal = legal;
        v.aluk = aluk; v.alub = alub; v.dr = dr; v.data = data; v.nzp = nzp; v.ovf = ovf;
        return v;
    endfunction

    // Writeback monitor: pops the scoreboard on every DR_we, checks NZP/Ovf a cycle later.
    logic pend = 1'b0;
    exp_t pend_e;
    always @(negedge Clk) begin
        if (!Reset_n) begin
            cur_nzp = 3'b010;
            pend    = 1'b0;
        end else begin
            if (pend) begin
                chk("wb_nzp", {29'd0, NZP}, {29'd0, pend_e.nzp});
`ifdef ALU_OVF_EN
                chk("wb_ovf", {31'd0, Ovf}, {31'd0, pend_e.ovf});
`endif
                cur_nzp = pend_e.nzp;
                pend    = 1'b0;
            end
            if (DR_we === 1'b1) begin
                if (sb.size() == 0) begin
                    fail_now("unexpected_dr_we");
                end else begin
                    pend_e = sb.pop_front();
                    chk("wb_addr", {29'd0, DR_addr}, {29'd0, pend_e.dr});
                    chk("wb_data", {16'd0, DR_data}, {16'd0, pend_e.data});
                    pend = 1'b1;
                end
            end
        end
    end

    task automatic preload(input logic [2:0] ia, input logic [15:0] va,
                           input logic [2:0] ib, input logic [15:0] vb);
        @(negedge Clk);
        pl_ia = ia; pl_va = va; pl_ib = ib; pl_vb = vb; pl_en = 1'b1;
        @(posedge Clk);
        #1 pl_en = 1'b0;
    endtask

    task automatic drive(input logic [15:0] instr);
        int n;
        n = 0;
        while (Instr_ready !== 1'b1 && n < 20) begin
            @(negedge Clk);
            n++;
        end
        if (Instr_ready !== 1'b1) fail_now("ready_timeout");
        Instr       = instr;
        Instr_valid = 1'b1;
        @(posedge Clk);
        #1 Instr_valid = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        logic [2:0] nzp_before;
        preload(v.ra, v.va, v.rb, v.vb);
        if (v.legal) sb.push_back('{v.dr, v.data, v.nzp, v.ovf});
        nzp_before = cur_nzp;
        drive(v.instr);
        @(negedge Clk);
        if (v.legal) chk("ready_busy", {31'd0, Instr_ready}, 32'd0);
        else begin
            chk("illegal_pulse", {31'd0, Illegal_op}, 32'd1);
            chk("illegal_ready", {31'd0, Instr_ready}, 32'd1);
        end
        @(negedge Clk);
        if (v.legal) begin
            chk("exec_aluk", {30'd0, ALUK}, {30'd0, v.aluk});
            chk("exec_alub", {16'd0, ALU_B}, {16'd0, v.alub});
        end else chk("illegal_one_cycle", {31'd0, Illegal_op}, 32'd0);
        @(negedge Clk);
        if (v.legal) chk("we_latency", {31'd0, DR_we}, 32'd1);
        @(negedge Clk);
        if (v.legal) chk("ready_again", {31'd0, Instr_ready}, 32'd1);
        else chk("illegal_nzp_held", {29'd0, NZP}, {29'd0, nzp_before});
    endtask

    // Reference model for random vectors, evaluated against the current register file.
    function automatic vec_t model(input logic [15:0] instr);
        vec_t v;
        logic [15:0] a, b, r;
        a = rf[instr[8:6]];
        if (instr[15:12] == 4'b1001) b = 16'hFFFF;
        else if (instr[5]) b = {{11{instr[4]}}, instr[4:0]};
        else b = rf[instr[2:0]];
        case (instr[15:12])
            4'b0001: begin r = a + b; v.aluk = 2'b00; end
            4'b0101: begin r = a & b; v.aluk = 2'b01; end
            default: begin r = ~a;    v.aluk = 2'b10; end
        endcase
        v.ra = instr[8:6]; v.va = a; v.rb = instr[2:0]; v.vb = rf[instr[2:0]];
        v.instr = instr; v.legal = 1'b1; v.alub = b; v.dr = instr[11:9]; v.data = r;
        v.nzp = r[15] ? 3'b100 : (r == 16'h0 ? 3'b010 : 3'b001);
        v.ovf = (instr[15:12] == 4'b0001) && (a[15] == b[15]) && (r[15] != a[15]);
        return v;
    endfunction

    initial begin
        vec_t vecs[10];
        vecs[0] = mk(3'd2, 16'h0005, 3'd3, 16'h0007, 16'h1283, 1, 2'b00, 16'h0007, 3'd1, 16'h000C, 3'b001, 0);
        vecs[1] = mk(3'd0, 16'h0000, 3'd0, 16'h0000, 16'h103F, 1, 2'b00, 16'hFFFF, 3'd0, 16'hFFFF, 3'b100, 0);
        vecs[2] = mk(3'd4, 16'h1234, 3'd4, 16'h1234, 16'h5920, 1, 2'b01, 16'h0000, 3'd4, 16'h0000, 3'b010, 0);
        vecs[3] = mk(3'd6, 16'h00FF, 3'd6, 16'h00FF, 16'h9BBF, 1, 2'b10, 16'hFFFF, 3'd5, 16'hFF00, 3'b100, 0);
        vecs[4] = mk(3'd0, 16'h0000, 3'd0, 16'h0000, 16'h0000, 0, 2'b00, 16'h0000, 3'd0, 16'h0000, 3'b000, 0);
        vecs[5] = mk(3'd2, 16'h7FFF, 3'd3, 16'h0001, 16'h1283, 1, 2'b00, 16'h0001, 3'd1, 16'h8000, 3'b100, 1);
        vecs[6] = mk(3'd1, 16'h0F0F, 3'd7, 16'h00FF, 16'h5647, 1, 2'b01, 16'h00FF, 3'd3, 16'h000F, 3'b001, 0);
        vecs[7] = mk(3'd2, 16'h7FFF, 3'd2, 16'h7FFF, 16'h14AF, 1, 2'b00, 16'h000F, 3'd2, 16'h800E, 3'b100, 1);
        vecs[8] = mk(3'd1, 16'h0003, 3'd1, 16'h0003, 16'h1241, 1, 2'b00, 16'h0003, 3'd1, 16'h0006, 3'b001, 0);
        vecs[9] = mk(3'd0, 16'h0000, 3'd0, 16'h0000, 16'hF025, 0, 2'b00, 16'h0000, 3'd0, 16'h0000, 3'b000, 0);

        Reset_n     = 1'b0;
        Instr       = 16'h0;
        Instr_valid = 1'b0;
        repeat (2) @(negedge Clk);
        chk("rst_ready", {31'd0, Instr_ready}, 32'd1);
        chk("rst_we", {31'd0, DR_we}, 32'd0);
        chk("rst_illegal", {31'd0, Illegal_op}, 32'd0);
        chk("rst_nzp", {29'd0, NZP}, 32'd2);
        chk("rst_aluk", {30'd0, ALUK}, 32'd3);
`ifdef ALU_OVF_EN
        chk("rst_ovf", {31'd0, Ovf}, 32'd0);
`endif
        Reset_n = 1'b1;

        for (int i = 0; i < 10; i++) run_vec(vecs[i]);

        for (int i = 0; i < 8; i++) begin
            logic [15:0] ins;
            logic [3:0]  op;
            case ($urandom_range(0, 2))
                0:       op = 4'b0001;
                1:       op = 4'b0101;
                default: op = 4'b1001;
            endcase
            ins = {op, 12'($urandom())};
            preload(ins[8:6], 16'($urandom()), ins[2:0], 16'($urandom()));
            run_vec(model(ins));
        end

        // Reset asserted during EXEC discards the instruction.
        preload(3'd2, 16'h0005, 3'd3, 16'h0007);
        drive(16'h1283);
        @(negedge Clk);
        @(negedge Clk);
        Reset_n = 1'b0;
        #1;
        chk("abort_we", {31'd0, DR_we}, 32'd0);
        chk("abort_nzp", {29'd0, NZP}, 32'd2);
        chk("abort_ready", {31'd0, Instr_ready}, 32'd1);
        @(negedge Clk);
        Reset_n = 1'b1;
        repeat (6) @(negedge Clk);
        chk("post_abort_ready", {31'd0, Instr_ready}, 32'd1);
        chk("post_abort_nzp", {29'd0, NZP}, 32'd2);

        // The block is usable again after the abort.
        run_vec(vecs[0]);
        repeat (3) @(negedge Clk);
        chk("sb_drained", sb.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

endmodule
